mshift_seq_unit: RTL

- Parametrised, iterative successor to the single-step 16-bit shift register.
- Shifts or rotates an operand by a programmable amount, one bit position per clock, under a start/busy/done handshake.
- Adds an arithmetic-right mode and a pass-through load mode.
- Sits beside the ALU datapath; the ALU sequencer issues a start and waits for done.

---
 rtl/mshift_seq_unit.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mshift_seq_unit.sv
// Iterative shifter/rotator: one bit position per clock under a start/busy/done handshake.
// Optional carry-out port is enabled with `define MSHIFT_CARRY_OUT_EN.
module mshift_seq_unit #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  logic             iClock,
    input  logic             iReset,
    input  logic             iStart,
    input  logic [WIDTH-1:0] iD,
    input  logic [2:0]       iCommand,
    input  logic [AMT_W-1:0] iAmount,
    output logic [WIDTH-1:0] oQ,
    output logic             oBusy,
    output logic             oDone
`ifdef MSHIFT_CARRY_OUT_EN
    ,
    output logic             oCarry
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    localparam logic [2:0] CMD_SRL = 3'b000;
    localparam logic [2:0] CMD_SLL = 3'b001;
    localparam logic [2:0] CMD_ROR = 3'b010;
    localparam logic [2:0] CMD_ROL = 3'b011;
    localparam logic [2:0] CMD_SRA = 3'b100;

    state_e             state_q, state_d;
    logic [2:0]         cmd_q, cmd_d;
    logic [AMT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   step_q;
    logic               step_out;
    logic               is_shift_cmd;

    // Single-bit step of the latched command, plus the bit that falls off.
    always_comb begin
        step_q   = q_q;
        step_out = 1'b0;
        case (cmd_q)
            CMD_SRL: begin step_q = {1'b0, q_q[WIDTH-1:1]};       step_out = q_q[0];       end
            CMD_SLL: begin step_q = {q_q[WIDTH-2:0], 1'b0};       step_out = q_q[WIDTH-1]; end
            CMD_ROR: begin step_q = {q_q[0], q_q[WIDTH-1:1]};     step_out = q_q[0];       end
            CMD_ROL: begin step_q = {q_q[WIDTH-2:0], q_q[WIDTH-1]}; step_out = q_q[WIDTH-1]; end
            CMD_SRA: begin step_q = {q_q[WIDTH-1], q_q[WIDTH-1:1]}; step_out = q_q[0];     end
            default: begin step_q = q_q;                          step_out = 1'b0;         end
        endcase
    end

    assign is_shift_cmd = (iCommand <= CMD_SRA);

`ifdef MSHIFT_CARRY_OUT_EN
    logic carry_q, carry_d;
`endif

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
`ifdef MSHIFT_CARRY_OUT_EN
        carry_d = carry_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (iStart) begin
                    q_d   = iD;
                    cmd_d = iCommand;
                    cnt_d = iAmount;
`ifdef MSHIFT_CARRY_OUT_EN
                    carry_d = 1'b0;
`endif
                    if (iAmount == '0 || !is_shift_cmd) state_d = S_DONE;
                    else                                 state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                q_d   = step_q;
                cnt_d = cnt_q - AMT_W'(1);
`ifdef MSHIFT_CARRY_OUT_EN
                carry_d = step_out;
`endif
                if (cnt_q == AMT_W'(1)) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Flags are registered off the next state so they line up with it.
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_q <= S_IDLE;
            cmd_q   <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MSHIFT_CARRY_OUT_EN
            carry_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef MSHIFT_CARRY_OUT_EN
            carry_q <= carry_d;
`endif
        end
    end

    assign oQ    = q_q;
    assign oBusy = busy_q;
    assign oDone = done_q;
`ifdef MSHIFT_CARRY_OUT_EN
    assign oCarry = carry_q;
`else
    logic unused_step_out;
    assign unused_step_out = step_out;
`endif

endmodule
